// File: rtl/datapath_controller.sv
// Host-facing sequencer for the SRAM datapath: turns READ/WRITE/COPY/ADD commands
// into primitive datapath read/write cycles and returns one response per command.
module datapath_controller #(
  parameter int unsigned ADDR_W = 7,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned RD_LAT = 2
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [ADDR_W-1:0] cmd_addr_a,
  input  logic [ADDR_W-1:0] cmd_addr_b,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic              busy,
  output logic [1:0]        dp_op_code,
  output logic [ADDR_W-1:0] dp_address_one,
  output logic [ADDR_W-1:0] dp_address_two,
  output logic [DATA_W-1:0] dp_data_in,
  input  logic [DATA_W-1:0] dp_data_out
);

  localparam int unsigned CNT_W = $clog2(RD_LAT + 1);
  localparam logic [CNT_W-1:0] WAIT_INIT = CNT_W'(RD_LAT - 1);

  localparam logic [1:0] OP_READ  = 2'b00;
  localparam logic [1:0] OP_WRITE = 2'b01;
  localparam logic [1:0] OP_COPY  = 2'b10;

  localparam logic [1:0] DP_IDLE  = 2'b00;
  localparam logic [1:0] DP_READ  = 2'b01;
  localparam logic [1:0] DP_WRITE = 2'b10;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    RD_A   = 3'd1,
    WAIT_A = 3'd2,
    RD_B   = 3'd3,
    WAIT_B = 3'd4,
    WR     = 3'd5,
    RESP   = 3'd6
  } state_t;

  state_t            state;
  logic [1:0]        lat_op;
  logic [CNT_W-1:0]  cnt;
  logic [DATA_W-1:0] opa;

  // Outputs are registered for the state being entered, so dp_* lines up with that state's cycle.
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      state          <= IDLE;
      lat_op         <= '0;
      cnt            <= '0;
      opa            <= '0;
      cmd_ready      <= 1'b1;
      rsp_valid      <= 1'b0;
      rsp_data       <= '0;
      busy           <= 1'b0;
      dp_op_code     <= DP_IDLE;
      dp_address_one <= '0;
      dp_address_two <= '0;
      dp_data_in     <= '0;
    end else begin
      dp_op_code <= DP_IDLE;
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            lat_op         <= cmd_op;
            dp_address_one <= cmd_addr_a;
            dp_address_two <= cmd_addr_b;
            cmd_ready      <= 1'b0;
            busy           <= 1'b1;
            if (cmd_op == OP_WRITE) begin
              state      <= WR;
              dp_op_code <= DP_WRITE;
              dp_data_in <= cmd_wdata;
            end else begin
              state      <= RD_A;
              dp_op_code <= DP_READ;
            end
          end
        end
        RD_A: begin
          state <= WAIT_A;
          cnt   <= WAIT_INIT;
        end
        WAIT_A: begin
          if (cnt == '0) begin
            opa <= dp_data_out;
            if (lat_op == OP_READ) begin
              state     <= RESP;
              rsp_valid <= 1'b1;
              rsp_data  <= dp_data_out;
            end else if (lat_op == OP_COPY) begin
              state          <= WR;
              dp_op_code     <= DP_WRITE;
              dp_address_one <= dp_address_two;
              dp_data_in     <= dp_data_out;
            end else begin
              state          <= RD_B;
              dp_op_code     <= DP_READ;
              dp_address_one <= dp_address_two;
            end
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        RD_B: begin
          state <= WAIT_B;
          cnt   <= WAIT_INIT;
        end
        WAIT_B: begin
          if (cnt == '0) begin
            state          <= WR;
            dp_op_code     <= DP_WRITE;
            dp_address_one <= dp_address_two;
            dp_data_in     <= opa + dp_data_out;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        WR: begin
          // The value written is the response for WRITE, COPY and ADD alike.
          state     <= RESP;
          rsp_valid <= 1'b1;
          rsp_data  <= dp_data_in;
        end
        RESP: begin
          if (rsp_ready) begin
            state     <= IDLE;
            rsp_valid <= 1'b0;
            cmd_ready <= 1'b1;
            busy      <= 1'b0;
          end
        end
        default: begin
          state     <= IDLE;
          rsp_valid <= 1'b0;
          cmd_ready <= 1'b1;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule
